// File: rtl/usb_tx_line_pkg.sv
// Shared types and constants for the full-speed USB transmit line driver.
//   d_port_t   : {dp,dn} pair driven to the PHY
//   USB_J/K/SE0: line symbols
//   tx_state_t : transmit sequencing states
package usb_tx_line_pkg;

  typedef struct packed {
    logic dp;
    logic dn;
  } d_port_t;

  localparam d_port_t USB_J   = '{dp: 1'b1, dn: 1'b0};
  localparam d_port_t USB_K   = '{dp: 1'b0, dn: 1'b1};
  localparam d_port_t USB_SE0 = '{dp: 1'b0, dn: 1'b0};

  // SYNC pattern, sent LSB first: 0000_0001
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Consecutive data ones that force a stuffed zero
  localparam int unsigned ONES_MAX = 6;
  localparam int unsigned ONES_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_tx_nrzi.sv
// Bit stuffer and NRZI encoder for the transmit path.
//   clk, rst_n   : clock, async active-low reset
//   clear        : restart at level J with the ones-counter at zero
//   bit_en       : a new line bit starts on this edge
//   data_bit     : data bit for that slot (ignored when a stuff bit is due)
//   stuff_req_c  : next slot must be a stuffed zero (six ones already sent)
//   level_c      : line level for the bit starting this edge (1 = J, 0 = K)
module usb_tx_nrzi
  import usb_tx_line_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic bit_en,
  input  logic data_bit,
  output logic stuff_req_c,
  output logic level_c
);

  logic              lvl;
  logic              lvl_n;
  logic [ONES_W-1:0] ones;
  logic [ONES_W-1:0] ones_n;
  logic              base_lvl;
  logic [ONES_W-1:0] base_ones;

  // Kept separate from the update logic so the requester sees only registers
  assign stuff_req_c = (ones == ONES_W'(ONES_MAX));

  // Stuff insertion and NRZI toggle: a zero (real or stuffed) toggles the line
  always_comb begin
    base_lvl  = clear ? 1'b1 : lvl;
    base_ones = clear ? '0 : ones;
    lvl_n     = base_lvl;
    ones_n    = base_ones;
    if (bit_en) begin
      if (base_ones == ONES_W'(ONES_MAX)) begin
        lvl_n  = ~base_lvl;
        ones_n = '0;
      end else if (!data_bit) begin
        lvl_n  = ~base_lvl;
        ones_n = '0;
      end else begin
        ones_n = base_ones + ONES_W'(1);
      end
    end
  end

  assign level_c = lvl_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl  <= 1'b1;
      ones <= '0;
    end else begin
      lvl  <= lvl_n;
      ones <= ones_n;
    end
  end

endmodule

// File: rtl/usb_tx_line.sv
// Full-speed USB transmit line driver: SYNC, bit-stuffed NRZI bytes, EOP.
//   clk, rst_n : USB clock, async active-low reset
//   tx_data    : packet byte, LSB first
//   tx_valid   : byte valid; low at a byte boundary ends the packet
//   tx_ready   : byte accepted on an edge with tx_valid & tx_ready
//   d          : {dp,dn} to the PHY
//   d_oe       : PHY output enable
//   tx_busy    : packet in progress
// The byte accepted in IDLE is the first data byte, so SYNC runs straight
// into DATA; handshake pulses then pace every following byte.
module usb_tx_line
  import usb_tx_line_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output d_port_t    d,
  output logic       d_oe,
  output logic       tx_busy
);

  localparam int unsigned DIV_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W   = 3;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  tx_state_t        state;
  tx_state_t        state_n;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_n;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_n;
  logic [7:0]       hold;
  logic [7:0]       hold_n;
  d_port_t          d_n;
  d_port_t          d_fix;
  logic             tx_ready_n;
  logic             oe_n;
  logic             tick;
  logic             accept;
  logic             load_line;
  logic             load_fix;
  logic             nrzi_clr;
  logic             nrzi_en;
  logic             nrzi_bit;
  logic             stuff_req_c;
  logic             line_level_c;

  usb_tx_nrzi u_nrzi (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (nrzi_clr),
    .bit_en      (nrzi_en),
    .data_bit    (nrzi_bit),
    .stuff_req_c (stuff_req_c),
    .level_c     (line_level_c)
  );

  assign tick   = (div == DIV_MAX);
  assign accept = tx_valid & tx_ready;

  // Next-state, bit sequencing and handshake
  always_comb begin
    state_n   = state;
    div_n     = div;
    bit_cnt_n = bit_cnt;
    hold_n    = hold;
    nrzi_clr  = 1'b0;
    nrzi_en   = 1'b0;
    nrzi_bit  = 1'b0;
    load_line = 1'b0;
    load_fix  = 1'b0;
    d_fix     = USB_J;

    if (state != IDLE) begin
      div_n = tick ? '0 : div + DIV_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          hold_n    = tx_data;
          state_n   = SYNC;
          bit_cnt_n = '0;
          nrzi_clr  = 1'b1;
          nrzi_en   = 1'b1;
          nrzi_bit  = SYNC_BYTE[0];
          load_line = 1'b1;
        end
      end
      SYNC, DATA: begin
        if (tick) begin
          if (stuff_req_c) begin
            // stuffed zero: no data bit consumed
            nrzi_en   = 1'b1;
            load_line = 1'b1;
          end else if (bit_cnt != BIT_LAST) begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            nrzi_en   = 1'b1;
            load_line = 1'b1;
            nrzi_bit  = (state == SYNC) ? SYNC_BYTE[bit_cnt_n] : hold[bit_cnt_n];
          end else if (state == SYNC) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            nrzi_en   = 1'b1;
            load_line = 1'b1;
            nrzi_bit  = hold[0];
          end else if (accept) begin
            hold_n    = tx_data;
            bit_cnt_n = '0;
            nrzi_en   = 1'b1;
            load_line = 1'b1;
            nrzi_bit  = tx_data[0];
          end else begin
            state_n   = EOP_SE0;
            bit_cnt_n = '0;
            load_fix  = 1'b1;
            d_fix     = USB_SE0;
          end
        end
      end
      EOP_SE0: begin
        if (tick) begin
          if (bit_cnt == '0) begin
            bit_cnt_n = BIT_W'(1);
          end else begin
            state_n   = EOP_J;
            bit_cnt_n = '0;
            load_fix  = 1'b1;
            d_fix     = USB_J;
          end
        end
      end
      EOP_J: begin
        if (tick) begin
          state_n  = IDLE;
          nrzi_clr = 1'b1;
          load_fix = 1'b1;
          d_fix    = USB_J;
        end
      end
      default: state_n = IDLE;
    endcase

    // Pulse in the last clk of a byte's final bit, or of its trailing stuff bit
    tx_ready_n = (state_n == IDLE) ||
                 ((state_n == DATA) && (div_n == DIV_MAX) &&
                  (bit_cnt_n == BIT_LAST) && !stuff_req_c);
    oe_n = (state_n != IDLE);
  end

  // Line symbol for the next clk
  always_comb begin
    d_n = d;
    if (load_line) begin
      d_n = line_level_c ? USB_J : USB_K;
    end else if (load_fix) begin
      d_n = d_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      hold     <= '0;
      d        <= USB_J;
      d_oe     <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      div      <= div_n;
      bit_cnt  <= bit_cnt_n;
      hold     <= hold_n;
      d        <= d_n;
      d_oe     <= oe_n;
      tx_ready <= tx_ready_n;
      tx_busy  <= oe_n;
    end
  end

endmodule
